// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin share of the SDRAM controller port with in-order burst ownership routing
module sdram_port_arbiter #(
  parameter int NUM_PORTS         = 2,
  parameter int BUS_WIDTH         = 8,
  parameter int PORT_ADDRESS_BITS = 21,
  parameter int BURST_LENGTH      = 8,
  parameter int OWNER_DEPTH       = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_PORTS-1:0]                   req,
  input  logic [NUM_PORTS-1:0]                   wren,
  input  logic [NUM_PORTS*PORT_ADDRESS_BITS-1:0] address,
  input  logic [NUM_PORTS*BUS_WIDTH-1:0]         wdata,
  output logic [NUM_PORTS-1:0]                   ready,
  output logic [NUM_PORTS-1:0]                   valid,
  output logic [BUS_WIDTH-1:0]                   rdata,
  output logic [2:0]                             offset,
  output logic                                   ctrl_req,
  output logic                                   ctrl_wren,
  output logic [PORT_ADDRESS_BITS-1:0]           ctrl_address,
  output logic [BUS_WIDTH-1:0]                   ctrl_to_mem,
  input  logic                                   ctrl_ready,
  input  logic                                   ctrl_valid,
  input  logic [2:0]                             ctrl_offset,
  input  logic [BUS_WIDTH-1:0]                   ctrl_from_mem,
  output logic                                   protocol_error
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int BW = $clog2(BURST_LENGTH);
  localparam int AW = $clog2(OWNER_DEPTH);
  localparam int CW = $clog2(OWNER_DEPTH + 1);
  logic [PW-1:0] rr_ptr, grant, head, first;
  logic [PW:0] sum;
  logic [PW-1:0] owner_q [OWNER_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [BW-1:0] beat_cnt;
  logic [2*NUM_PORTS-1:0] req2;
  logic [NUM_PORTS-1:0] rot;
  logic accept, beat, pop;
  // requests rotated so bit 0 is the rr_ptr port; lowest set bit wins
  always_comb begin
    req2 = {req, req} >> rr_ptr;
    rot = req2[NUM_PORTS-1:0];
    first = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--)
      if (rot[p]) first = PW'(p);
    sum = (PW+1)'(rr_ptr) + (PW+1)'(first);
    grant = sum >= (PW+1)'(NUM_PORTS) ? PW'(sum - (PW+1)'(NUM_PORTS)) : PW'(sum);
    head = owner_q[rd_ptr];
    ctrl_req = |req && count < CW'(OWNER_DEPTH);
    accept = ctrl_req && ctrl_ready;
    ready = accept ? NUM_PORTS'(1) << grant : '0;
    beat = ctrl_valid && count != '0;
    pop = beat && beat_cnt == BW'(BURST_LENGTH - 1);
    valid = beat ? NUM_PORTS'(1) << head : '0;
    ctrl_wren = 1'b0;
    ctrl_address = '0;
    ctrl_to_mem = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (PW'(p) == grant) begin
        ctrl_wren = wren[p];
        ctrl_address = address[p*PORT_ADDRESS_BITS +: PORT_ADDRESS_BITS];
      end
      if (PW'(p) == head) ctrl_to_mem = wdata[p*BUS_WIDTH +: BUS_WIDTH];
    end
    rdata = ctrl_from_mem;
    offset = ctrl_offset;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      beat_cnt <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (accept) begin
        owner_q[wr_ptr] <= grant;
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= grant == PW'(NUM_PORTS - 1) ? '0 : grant + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(accept) - CW'(pop);
      if (beat) beat_cnt <= pop ? '0 : beat_cnt + 1'b1;
      if (ctrl_valid && count == '0) protocol_error <= 1'b1;
    end
  end
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single request/data port of the SDRAM controller among NUM_PORTS requesters (e.g. host command path, verify engine, programmer datapath). Round-robin arbitration selects which requester's command is presented to the controller. An in-order owner FIFO routes each returned burst, read or write, back to the requester that issued it. The block sits directly between the requester blocks and the SDRAM controller's p1 port.

## Interface
- NUM_PORTS, 2: number of requesters, 2..4.
- BUS_WIDTH, 8: data word width.
- PORT_ADDRESS_BITS, 21: word address width.
- BURST_LENGTH, 8: words per command; power of two, 2..8.
- OWNER_DEPTH, 4: maximum commands accepted but not yet fully transferred; power of two.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  NUM_PORTS  per-port command request, held until accepted.
- wren  in  NUM_PORTS  per-port write (1) / read (0).
- address  in  NUM_PORTS*PORT_ADDRESS_BITS  per-port address; port i at bits [i*PORT_ADDRESS_BITS +: PORT_ADDRESS_BITS].
- wdata  in  NUM_PORTS*BUS_WIDTH  per-port write data, packed the same way.
- ready  out  NUM_PORTS  port i command accepted this cycle.
- valid  out  NUM_PORTS  port i data beat this cycle.
- rdata  out  BUS_WIDTH  read data, broadcast to all ports.
- offset  out  3  beat index within the burst, broadcast.
- ctrl_req, ctrl_wren, ctrl_address  out  1, 1, PORT_ADDRESS_BITS  command to the controller.
- ctrl_to_mem  out  BUS_WIDTH  write data to the controller.
- ctrl_ready  in  1  controller accepts a command this cycle.
- ctrl_valid  in  1  data beat: read data valid, or write data sampled.
- ctrl_offset  in  3  controller beat index.
- ctrl_from_mem  in  BUS_WIDTH  read data from the controller.
- protocol_error  out  1  sticky error flag.

## Operation
**Registered state**
- rr_ptr: index of the highest-priority port.
- Owner FIFO: OWNER_DEPTH entries of $clog2(NUM_PORTS) bits, with read/write pointers and a count.
- beat_cnt: $clog2(BURST_LENGTH) bits.
- protocol_error.

**Arbitration (combinational)**
- grant = first port with req=1, searching from rr_ptr upward and wrapping.
- ctrl_req = |req & (fifo count < OWNER_DEPTH).
- ctrl_address and ctrl_wren come from the granted port.

**Command acceptance**
- accept = ctrl_req & ctrl_ready.
- ready[grant] = accept; all other ready bits are 0.
- On accept: push grant into the owner FIFO, and set rr_ptr = (grant+1) mod NUM_PORTS.
- When no accept occurs, rr_ptr holds.

**Data routing**
- head = owner FIFO head entry.
- valid[i] = ctrl_valid & (fifo count != 0) & (head == i).
- ctrl_to_mem = wdata[head].
- rdata = ctrl_from_mem and offset = ctrl_offset, both passed through.

**Burst tracking**
- Each ctrl_valid cycle increments beat_cnt.
- When beat_cnt == BURST_LENGTH-1 on a ctrl_valid cycle: beat_cnt returns to 0 and the FIFO is popped.
- The controller delivers bursts strictly in command order, as BURST_LENGTH contiguous valid cycles.

**Simultaneous events**
- Push and pop in the same cycle leave the count unchanged. Both pointers advance and wrap mod OWNER_DEPTH.

**Error handling**
- ctrl_valid while the FIFO count is 0 sets protocol_error, which stays set until rst.
- In this case no valid bit is asserted and beat_cnt does not advance.

**Reset**
- FIFO cleared (count 0, pointers 0); rr_ptr = 0; beat_cnt = 0; protocol_error = 0.
- Reset mid-burst discards all outstanding ownership.
- Outputs immediately after reset: ready = 0 and valid = 0 (FIFO empty); ctrl_req follows |req.

## Timing
- Zero-cycle command path: ctrl_req, ctrl_address, ctrl_wren and ready are combinational from req, rr_ptr, FIFO count and ctrl_ready.
- A requester must hold req, wren and address stable until it sees ready=1. Dropping req before acceptance is allowed; it is simply not arbitrated.
- Zero-cycle data path: valid, ctrl_to_mem and rdata are combinational from ctrl_valid and head.
- Writers present wdata in every cycle in which their valid is high.
- The FIFO push and the rr_ptr update take effect on the clock edge after accept.
- A port can be granted again in the cycle after its own acceptance only if no other port is requesting.
- FIFO full: ctrl_req = 0 until a pop. The pop and a new accept can occur on consecutive cycles, never the same cycle while full.

## Test plan
- **Single read.** Port 0 reads address 0x00010 → ready[0] in the cycle ctrl_ready=1; after 8 ctrl_valid beats with offsets 0..7, valid[0]=1 for those 8 cycles, valid[1]=0, FIFO empty.
- **Round-robin fairness.** Both ports hold req continuously; ctrl_ready pulses 6 times → acceptance order 0,1,0,1,0,1, and owners are returned in that same order.
- **Write routing.** Port 1 writes with wdata = 0xA0 + offset; port 0 reads → ctrl_to_mem = 0xA0..0xA7 during port 1's burst, and valid[0] is asserted only during port 0's burst.
- **FIFO full.** OWNER_DEPTH=4; 4 commands accepted with ctrl_valid held low → ctrl_req=0 and ready=0. After 8 beats, exactly one pop occurs and ctrl_req returns to 1.
- **Push/pop same cycle.** A final beat coincides with an accept → count unchanged and the head advances to the next owner.
- **Error and reset.** ctrl_valid with an empty FIFO → protocol_error=1 and no valid asserted. Reset asserted mid-burst → count 0, protocol_error 0, rr_ptr 0.
